// File: rtl/pk_vga_scan.sv
// pk_vga_scan: shared types and helpers for the VGA scan generator.
// Contents: region_e (position inside one axis), timing_t (per-pixel flag bundle),
// total() (axis period from its four region lengths).
package pk_vga_scan;
    typedef enum logic [1:0] {SYNC, BACKPORCH, DISPLAY, FRONTPORCH} region_e;
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame_start;
    } timing_t;
    function automatic int total(input int sync_len, input int bp_len, input int act_len, input int fp_len);
        return sync_len + bp_len + act_len + fp_len;
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (pixels of a line or lines of a frame), region order sync/bp/active/fp.
// Ports: clk, rst (async, active high), en (count enable);
//        wrap (counter at last position), sync / active (region flags), first (first active position).
module vga_axis_counter
    import pk_vga_scan::*;
#(
    parameter int SYNC_LEN = 96,
    parameter int BP_LEN   = 48,
    parameter int ACT_LEN  = 640,
    parameter int FP_LEN   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap,
    output logic sync,
    output logic active,
    output logic first
);
    localparam int TOTAL = total(SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN);
    localparam int CW = $clog2(TOTAL);
    logic [CW-1:0] cnt_q, cnt_d;
    region_e region;
    if (SYNC_LEN < 1 || BP_LEN < 1 || ACT_LEN < 1 || FP_LEN < 1) begin : g_len_err
        $error("vga_axis_counter: every region length must be at least 1");
    end
    always_comb begin
        wrap   = cnt_q == CW'(TOTAL - 1);
        cnt_d  = en ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        region = cnt_q < CW'(SYNC_LEN) ? SYNC :
                 cnt_q < CW'(SYNC_LEN + BP_LEN) ? BACKPORCH :
                 cnt_q < CW'(SYNC_LEN + BP_LEN + ACT_LEN) ? DISPLAY : FRONTPORCH;
        sync   = region == SYNC;
        active = region == DISPLAY;
        first  = cnt_q == CW'(SYNC_LEN + BP_LEN);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: parametrised VGA timing plus zoomed frame-buffer addressing with read-latency alignment.
// Ports: piul1Clock/piul1Reset (async, active high)/piul1Enable (pixel strobe, low freezes everything);
//        poulAddr -> buffer, piulRgb <- buffer {R,G,B} RD_LATENCY cycles later;
//        poulRed/Green/Blue, poul1HSync, poul1VSync, poul1Blank_n, poul1FrameStart -> DAC, all mutually aligned.
module vga_scan_generator
    import pk_vga_scan::*;
#(
    parameter int H_ACT           = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACT           = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int ZOOM_LOG2       = 1,
    parameter int BUF_H           = 320,
    parameter int BUF_V           = 240,
    parameter int ADDR_W          = 17,
    parameter int COLOR_W         = 4,
    parameter int RD_LATENCY      = 1
) (
    input  logic                   piul1Clock,
    input  logic                   piul1Reset,
    input  logic                   piul1Enable,
    output logic [ADDR_W-1:0]      poulAddr,
    input  logic [3*COLOR_W-1:0]   piulRgb,
    output logic [COLOR_W-1:0]     poulRed,
    output logic [COLOR_W-1:0]     poulGreen,
    output logic [COLOR_W-1:0]     poulBlue,
    output logic                   poul1HSync,
    output logic                   poul1VSync,
    output logic                   poul1Blank_n,
    output logic                   poul1FrameStart
);
    localparam int ZW = ZOOM_LOG2 > 0 ? ZOOM_LOG2 : 1;
    localparam logic [ZW-1:0] ZMAX = ZW'((1 << ZOOM_LOG2) - 1);
    localparam int RGB_W = 3 * COLOR_W;
    if (H_ACT != (BUF_H << ZOOM_LOG2) || V_ACT != (BUF_V << ZOOM_LOG2)) begin : g_zoom_err
        $error("vga_scan_generator: active area must equal the buffer scaled by 2**ZOOM_LOG2");
    end
    if (BUF_H * BUF_V > (1 << ADDR_W)) begin : g_addr_err
        $error("vga_scan_generator: buffer does not fit in ADDR_W address bits");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_err
        $error("vga_scan_generator: RD_LATENCY must be 1..4");
    end
    logic h_wrap, h_sync, h_act, h_first, v_wrap, v_sync, v_act, v_first;
    vga_axis_counter #(.SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .ACT_LEN(H_ACT), .FP_LEN(H_FP)) u_h (
        .clk(piul1Clock), .rst(piul1Reset), .en(piul1Enable),
        .wrap(h_wrap), .sync(h_sync), .active(h_act), .first(h_first)
    );
    vga_axis_counter #(.SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .ACT_LEN(V_ACT), .FP_LEN(V_FP)) u_v (
        .clk(piul1Clock), .rst(piul1Reset), .en(piul1Enable & h_wrap),
        .wrap(v_wrap), .sync(v_sync), .active(v_act), .first(v_first)
    );
    timing_t s0, s1_q, s1_d, out_q, out_d;
    timing_t dl_q [RD_LATENCY];
    timing_t dl_d [RD_LATENCY];
    logic [ZW-1:0] col_sub_q, col_sub_d, row_sub_q, row_sub_d;
    logic [ADDR_W-1:0] col_q, col_d, base_q, base_d, addr_q, addr_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    always_comb begin
        s0        = {h_sync, v_sync, h_act & v_act, h_first & v_first};
        col_sub_d = col_sub_q;
        col_d     = col_q;
        row_sub_d = row_sub_q;
        base_d    = base_q;
        addr_d    = addr_q;
        s1_d      = s1_q;
        dl_d      = dl_q;
        out_d     = out_q;
        rgb_d     = rgb_q;
        if (piul1Enable) begin
            s1_d   = s0;
            addr_d = s0.active ? base_q + col_q : addr_q;
            if (s0.active) begin
                col_sub_d = col_sub_q == ZMAX ? '0 : col_sub_q + 1'b1;
                col_d     = col_sub_q == ZMAX ? col_q + 1'b1 : col_q;
            end
            // Line end: restart the column; every 2**ZOOM_LOG2-th active line moves the base one buffer row down.
            if (h_wrap) begin
                col_sub_d = '0;
                col_d     = '0;
                if (v_wrap) begin
                    row_sub_d = '0;
                    base_d    = '0;
                end else if (v_act) begin
                    row_sub_d = row_sub_q == ZMAX ? '0 : row_sub_q + 1'b1;
                    base_d    = row_sub_q == ZMAX ? base_q + ADDR_W'(BUF_H) : base_q;
                end
            end
            // Flags wait RD_LATENCY stages so they meet the buffer data at the capture register.
            dl_d[0] = s1_q;
            for (int i = 1; i < RD_LATENCY; i++) dl_d[i] = dl_q[i-1];
            out_d = dl_q[RD_LATENCY-1];
            rgb_d = dl_q[RD_LATENCY-1].active ? piulRgb : '0;
        end
    end
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            col_sub_q <= '0;
            col_q     <= '0;
            row_sub_q <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            s1_q      <= '0;
            dl_q      <= '{default: '0};
            out_q     <= '0;
            rgb_q     <= '0;
        end else begin
            col_sub_q <= col_sub_d;
            col_q     <= col_d;
            row_sub_q <= row_sub_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            s1_q      <= s1_d;
            dl_q      <= dl_d;
            out_q     <= out_d;
            rgb_q     <= rgb_d;
        end
    end
    // Sync flags are stored as "asserted"; the polarity is applied only at the pins.
    assign poulAddr        = addr_q;
    assign poulRed         = rgb_q[RGB_W-1 -: COLOR_W];
    assign poulGreen       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign poulBlue        = rgb_q[COLOR_W-1:0];
    assign poul1HSync      = out_q.hsync ^ (SYNC_ACTIVE_LOW != 0);
    assign poul1VSync      = out_q.vsync ^ (SYNC_ACTIVE_LOW != 0);
    assign poul1Blank_n    = out_q.active;
    assign poul1FrameStart = out_q.frame_start;
endmodule

// File: doc/vga_scan_generator.md
Name: vga_scan_generator

Overview:
- Parametrised successor of the fixed 640x480@60 VGA driver.
- Generates VGA timing for any resolution and sync polarity from one pixel clock.
- Produces frame-buffer read addresses for a buffer upscaled by 2^ZOOM_LOG2, without dividers.
- Compensates a configurable buffer read latency so RGB, syncs and blank leave the block mutually aligned.
- Sits between the frame buffer read port and the VGA DAC pins.

Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low
- ZOOM_LOG2, 1, upscale factor 2^ZOOM_LOG2 in both axes
- BUF_H, 320, buffer width in pixels
- BUF_V, 240, buffer height in lines
- ADDR_W, 17, buffer address width
- COLOR_W, 4, bits per colour channel, input and output
- RD_LATENCY, 1, buffer read latency (clocks, 1..4)

Ports:
- piul1Clock  in  1  pixel clock
- piul1Reset  in  1  asynchronous, active-high reset
- piul1Enable  in  1  pixel strobe; low freezes the whole block
- poulAddr  out  ADDR_W  buffer read address
- piulRgb  in  3*COLOR_W  buffer read data {R,G,B}
- poulRed  out  COLOR_W  red channel
- poulGreen  out  COLOR_W  green channel
- poulBlue  out  COLOR_W  blue channel
- poul1HSync  out  1  horizontal sync
- poul1VSync  out  1  vertical sync
- poul1Blank_n  out  1  1 = active video
- poul1FrameStart  out  1  one-cycle pulse on the first active pixel of a frame

Behaviour:
- Reset: all counters 0. Syncs at the inactive level (SYNC_ACTIVE_LOW ? 1 : 0). Blank_n, RGB, Addr and FrameStart all 0. Delay lines cleared.
- H counter runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP.
  - Sync region: [0, H_SYNC).
  - Back porch follows.
  - Active region: [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT).
  - Front porch follows.
- V counter uses the same region order in lines. It increments when the H counter wraps and itself wraps at V_TOTAL-1.
- Piul1Enable = 0: counters, address logic and every pipeline register hold their values; the outputs hold.
- Stage S0: counters. Stage S1: registered Addr, active flag and raw syncs. Buffer data is valid RD_LATENCY cycles after S1. RGB is registered on capture.
- Total latency from the S0 counter value to all pins is RD_LATENCY+2 enabled cycles. Syncs, Blank_n and FrameStart go through delay lines of matching depth.
- RGB = 0 whenever the delayed active flag is 0. No stale data is ever shown during blanking.
- Address generation (incremental, no multiply or divide):
  - Column: a sub-counter counts 2^ZOOM_LOG2 active pixels, then the column index increments.
  - Row: line base = row*BUF_H. It advances by BUF_H at the end of every 2^ZOOM_LOG2-th active line.
  - Addr = line base + column. Column resets at the start of each line; line base resets at V counter wrap.
  - Addr holds its last value outside the active region.
- Elaboration error unless H_ACT == BUF_H<<ZOOM_LOG2, V_ACT == BUF_V<<ZOOM_LOG2, and BUF_H*BUF_V <= 2^ADDR_W.
- All porch and sync parameters must be >= 1.
- Reset mid-frame: the next frame starts cleanly at H=0, V=0. The first FrameStart arrives exactly after one full blanking-to-active interval.

Decomposition:
- Package pk_vga_scan holds:
  - typedef enum for timing regions {SYNC, BACKPORCH, DISPLAY, FRONTPORCH}
  - packed struct of timing flags {hsync, vsync, active, frame_start}
  - a function returning total = sync+bp+act+fp
- One sub-module, vga_axis_counter, is instantiated twice (H and V):
  - Parameters: sync/bp/act/fp lengths.
  - Inputs: count-enable.
  - Outputs: wrap pulse, sync flag, active flag.

Test Plan:
- Default parameters, 2 frames -> hsync low exactly 96 of every 800 cycles. Vsync low for 1600 cycles every 420000. Blank_n high for 640 cycles per active line.
- Address sequence, default zoom -> line 0 addresses 0,0,1,1,...,319,319. Line 1 repeats line 0. Line 2 starts at 320. The last active pixel reads 76799.
- Latency and alignment, RD_LATENCY=3, model returns data = Addr after 3 cycles -> pins show {R,G,B} matching the address with Blank_n high. RGB = 0 on every blank cycle. Edges are aligned to the same cycle as the syncs.
- Small configuration H_ACT=8, V_ACT=4, ZOOM_LOG2=2, BUF 2x1, SYNC_ACTIVE_LOW=0 -> syncs pulse high. Addresses are 0x4,1x4 on every line. FrameStart appears once per frame.
- Enable asserted every 2nd cycle -> every output sequence equals the full-rate sequence with each value held for 2 clocks.
- Reset asserted asynchronously mid-line during active video -> outputs take reset values immediately, before the next edge. After release, the first FrameStart occurs after (V_SYNC+V_BP)*H_TOTAL + H_SYNC+H_BP + RD_LATENCY+2 cycles.
